// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline-stage register (pipe_skid_reg)
// and its storage slot (pipe_slot).
//   - Default field widths used by every pipeline-stage instance.
//   - State encoding of the stage handshake FSM.
//   - Operation codes that the stage FSM issues to each storage slot.
// -----------------------------------------------------------------------------
package pipe_pkg;

    // Default field widths shared by ID/EX, EX/MEM and MEM/WB instances
    localparam int PIPE_CTRL_W = 20;
    localparam int PIPE_DATA_W = 36;
    localparam int PIPE_PC_W   = 8;

    // Stage occupancy state
    typedef logic [1:0] state_t;
    localparam state_t EMPTY = 2'd0;  // no entries held
    localparam state_t BUSY  = 2'd1;  // main entry holds an item
    localparam state_t FULL  = 2'd2;  // main and skid entries hold items

    // Per-slot update operation
    typedef logic [2:0] slot_op_t;
    localparam slot_op_t SLOT_HOLD  = 3'd0;  // keep contents
    localparam slot_op_t SLOT_LOAD  = 3'd1;  // copy all fields from inputs
    localparam slot_op_t SLOT_DRAIN = 3'd2;  // zero ctrl/data, keep pc
    localparam slot_op_t SLOT_FLUSH = 3'd3;  // zero ctrl/data, load pc
    localparam slot_op_t SLOT_CLEAR = 3'd4;  // zero every field

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One ctrl/data/pc storage entry of the elastic pipeline register. The owning
// stage selects what happens to the entry each cycle through op_i.
//
// Ports:
//   clk     in   stage clock, rising edge
//   rst     in   asynchronous active-low reset, zeroes every field
//   op_i    in   slot operation (SLOT_* from pipe_pkg)
//   ctrl_i  in   CTRL_W control bundle to load
//   data_i  in   DATA_W payload to load
//   pc_i    in   PC_W pc value to load (also used by SLOT_FLUSH)
//   ctrl_o  out  stored control bundle (registered)
//   data_o  out  stored payload (registered)
//   pc_o    out  stored pc (registered)
// -----------------------------------------------------------------------------
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int PC_W   = PIPE_PC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        op_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [PC_W-1:0]   pc_o
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [PC_W-1:0]   pc_q,   pc_d;

    // Next-entry selection from the requested slot operation
    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        pc_d   = pc_q;
        case (op_i)
            SLOT_HOLD: begin
                ctrl_d = ctrl_q;
                data_d = data_q;
                pc_d   = pc_q;
            end
            SLOT_LOAD: begin
                ctrl_d = ctrl_i;
                data_d = data_i;
                pc_d   = pc_i;
            end
            SLOT_DRAIN: begin
                // pc is deliberately kept so an idle stage still shows
                // the last pc that passed through it
                ctrl_d = {CTRL_W{1'b0}};
                data_d = {DATA_W{1'b0}};
                pc_d   = pc_q;
            end
            SLOT_FLUSH: begin
                ctrl_d = {CTRL_W{1'b0}};
                data_d = {DATA_W{1'b0}};
                pc_d   = pc_i;
            end
            SLOT_CLEAR: begin
                ctrl_d = {CTRL_W{1'b0}};
                data_d = {DATA_W{1'b0}};
                pc_d   = {PC_W{1'b0}};
            end
            default: begin
                ctrl_d = {CTRL_W{1'b0}};
                data_d = {DATA_W{1'b0}};
                pc_d   = {PC_W{1'b0}};
            end
        endcase
    end

    // Entry storage with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= {CTRL_W{1'b0}};
            data_q <= {DATA_W{1'b0}};
            pc_q   <= {PC_W{1'b0}};
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
            pc_q   <= pc_d;
        end
    end

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;
    assign pc_o   = pc_q;

endmodule : pipe_slot

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Elastic pipeline-stage register with a 2-entry skid buffer. Carries a
// control bundle and data payload (both zeroed on flush) and a pc field
// (loaded from in_pc on flush) between two pipeline stages using valid/ready
// on both sides. in_ready is decoded from the state register only, so there
// is no combinational path from out_ready to in_ready, and full throughput is
// kept under backpressure by parking one extra item in the skid entry.
//
// Optional build macro: PIPE_SKID_STATS_EN adds stall_cnt / flush_cnt.
//
// Ports:
//   clk        in   stage clock, rising edge
//   rst        in   asynchronous active-low reset
//   flush      in   synchronous flush, highest priority after rst
//   in_valid   in   upstream has an item
//   in_ready   out  stage can accept an item (state-register decode)
//   in_ctrl    in   CTRL_W control bundle
//   in_data    in   DATA_W data payload
//   in_pc      in   PC_W pc field
//   out_valid  out  main entry holds an item
//   out_ready  in   downstream accepts
//   out_ctrl   out  registered control bundle
//   out_data   out  registered payload
//   out_pc     out  registered pc
//   stall_cnt  out  16-bit saturating stall counter  (PIPE_SKID_STATS_EN)
//   flush_cnt  out  16-bit saturating flush counter  (PIPE_SKID_STATS_EN)
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int PC_W   = PIPE_PC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    logic [1:0] state_q, state_d;
    logic       in_fire;
    logic       out_fire;
    logic       from_skid;
    logic [2:0] main_op;
    logic [2:0] skid_op;

    logic [CTRL_W-1:0] main_ctrl_in, skid_ctrl;
    logic [DATA_W-1:0] main_data_in, skid_data;
    logic [PC_W-1:0]   main_pc_in,   skid_pc;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Main entry refills from skid only when draining FULL; a flush always
    // takes in_pc so the flushed stage reports the redirect pc.
    assign from_skid    = (state_q == FULL) && !flush;
    assign main_ctrl_in = from_skid ? skid_ctrl : in_ctrl;
    assign main_data_in = from_skid ? skid_data : in_data;
    assign main_pc_in   = from_skid ? skid_pc   : in_pc;

    // Occupancy state transition
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) state_d = BUSY;
                    else         state_d = EMPTY;
                end
                BUSY: begin
                    if (in_fire && !out_fire)      state_d = FULL;
                    else if (!in_fire && out_fire) state_d = EMPTY;
                    else                           state_d = BUSY;
                end
                FULL: begin
                    if (out_fire) state_d = BUSY;
                    else          state_d = FULL;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Slot operations for the main (output) and skid entries
    always_comb begin
        main_op = SLOT_HOLD;
        skid_op = SLOT_HOLD;
        if (flush) begin
            main_op = SLOT_FLUSH;
            skid_op = SLOT_CLEAR;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) main_op = SLOT_LOAD;
                    else         main_op = SLOT_HOLD;
                    skid_op = SLOT_HOLD;
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_op = SLOT_LOAD;
                        skid_op = SLOT_HOLD;
                    end else if (in_fire) begin
                        // downstream stalled: park the new item in skid
                        main_op = SLOT_HOLD;
                        skid_op = SLOT_LOAD;
                    end else if (out_fire) begin
                        main_op = SLOT_DRAIN;
                        skid_op = SLOT_HOLD;
                    end else begin
                        main_op = SLOT_HOLD;
                        skid_op = SLOT_HOLD;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_op = SLOT_LOAD;
                        skid_op = SLOT_CLEAR;
                    end else begin
                        main_op = SLOT_HOLD;
                        skid_op = SLOT_HOLD;
                    end
                end
                default: begin
                    main_op = SLOT_CLEAR;
                    skid_op = SLOT_CLEAR;
                end
            endcase
        end
    end

    // Occupancy state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .op_i   (main_op),
        .ctrl_i (main_ctrl_in),
        .data_i (main_data_in),
        .pc_i   (main_pc_in),
        .ctrl_o (out_ctrl),
        .data_o (out_data),
        .pc_o   (out_pc)
    );

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .op_i   (skid_op),
        .ctrl_i (in_ctrl),
        .data_i (in_data),
        .pc_i   (in_pc),
        .ctrl_o (skid_ctrl),
        .data_o (skid_data),
        .pc_o   (skid_pc)
    );

`ifdef PIPE_SKID_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    // Saturating stall / flush event counters, cleared only by rst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= 16'h0000;
            flush_q <= 16'h0000;
        end else begin
            if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'h0001;
            end
            if (flush && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 16'h0001;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`endif

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Scoreboard bench for pipe_skid_reg. A reference model keeps the items held
// by the stage as a plain FIFO queue of capacity 2; a monitor on the falling
// edge compares the DUT outputs against the queue head.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;
    localparam int CW = 20;
    localparam int DW = 36;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic [PW-1:0] in_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [PW-1:0] out_pc;
`ifdef PIPE_SKID_STATS_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .PC_W(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .out_pc    (out_pc)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic [PW-1:0] p;
    } item_t;

    item_t         sb_q[$];
    logic [PW-1:0] hold_pc = '0;
    bit            acc_m = 1'b0;
    logic [15:0]   stall_m = 16'h0000;
    logic [15:0]   flush_m = 16'h0000;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two items
    initial forever begin
        bit in_f;
        bit out_f;
        @(posedge clk or negedge rst);
        if (!rst) begin
            sb_q.delete();
            hold_pc = '0;
            acc_m   = 1'b0;
            stall_m = 16'h0000;
            flush_m = 16'h0000;
        end else begin
            in_f  = in_valid && (sb_q.size() < 2);
            out_f = out_ready && (sb_q.size() > 0);
            if ((sb_q.size() > 0) && !out_ready && (stall_m != 16'hFFFF)) stall_m = stall_m + 16'd1;
            if (flush) begin
                if (flush_m != 16'hFFFF) flush_m = flush_m + 16'd1;
                sb_q.delete();
                hold_pc = in_pc;
                acc_m   = 1'b0;
            end else begin
                if (out_f) begin
                    hold_pc = sb_q[0].p;
                    void'(sb_q.pop_front());
                end
                if (in_f) sb_q.push_back(item_t'{in_ctrl, in_data, in_pc});
                acc_m = in_f;
            end
        end
    end

    // Monitor: compare outputs against the model on the falling edge
    initial forever begin
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
        if (sb_q.size() > 0) begin
            chk("out_ctrl", 64'(out_ctrl), 64'(sb_q[0].c));
            chk("out_data", 64'(out_data), 64'(sb_q[0].d));
            chk("out_pc", 64'(out_pc), 64'(sb_q[0].p));
        end else begin
            chk("idle_ctrl", 64'(out_ctrl), 64'd0);
            chk("idle_data", 64'(out_data), 64'd0);
            chk("idle_pc", 64'(out_pc), 64'(hold_pc));
        end
`ifdef PIPE_SKID_STATS_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
        chk("flush_cnt", 64'(flush_cnt), 64'(flush_m));
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Hold the presented item until the model sees it accepted
    task automatic wait_acc();
        for (int k = 0; k < 50; k++) begin
            cyc();
            if (acc_m) break;
        end
        if (!acc_m) chk("accept_timeout", 64'(acc_m), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic put(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic [PW-1:0] p);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        in_pc    = p;
        wait_acc();
    endtask

    initial begin
        #12 rst = 1'b1;
        cyc();

        // Pass-through with downstream always ready
        out_ready = 1'b1;
        put(20'h3A5A5, 36'h012340042, 8'h05);
        for (int i = 0; i < 4; i++) put(CW'($urandom), {4'($urandom), $urandom}, 8'(8'h10 + i));
        repeat (3) cyc();

        // Backpressure: A, B fill the stage, C is held off
        out_ready = 1'b0;
        put(20'h0000A, 36'h00000000A, 8'h11);
        put(20'h0000B, 36'h00000000B, 8'h22);
        in_valid = 1'b1; in_ctrl = 20'h0000C; in_data = 36'h00000000C; in_pc = 8'h33;
        repeat (2) cyc();
        out_ready = 1'b1;
        wait_acc();
        repeat (4) cyc();

        // Flush while FULL with a valid input present
        out_ready = 1'b0;
        put(20'h11111, 36'h111111111, 8'h41);
        put(20'h22222, 36'h222222222, 8'h42);
        flush = 1'b1; in_valid = 1'b1;
        in_ctrl = 20'hFFFFF; in_data = 36'hFFFFFFFFF; in_pc = 8'h20;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_pc", 64'(out_pc), 64'h20);
        chk("flush_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) cyc();

        // Simultaneous in_fire / out_fire, pc 1..8
        for (int i = 1; i <= 8; i++) put(CW'($urandom), {4'($urandom), $urandom}, 8'(i));
        repeat (3) cyc();

        // Randomized traffic with occasional flush and one mid-stream reset
        for (int n = 0; n < 1500; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            if (!in_valid || acc_m) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_ctrl  = CW'($urandom);
                in_data  = {4'($urandom), $urandom};
                in_pc    = 8'($urandom);
            end
            if (n == 700) begin
                rst = 1'b0;
                #1;
                chk("rst_valid", 64'(out_valid), 64'd0);
                chk("rst_ready", 64'(in_ready), 64'd1);
                chk("rst_ctrl", 64'(out_ctrl), 64'd0);
                chk("rst_data", 64'(out_data), 64'd0);
                chk("rst_pc", 64'(out_pc), 64'd0);
                #3 rst = 1'b1;
            end
            cyc();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule : tb_pipe_skid_reg
